// File: rtl/rv_pkg.sv
// Shared RV32I integer-core definitions: data width, register count,
// register-index width and the hardwired-zero register index.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // True when the index names x0, which always reads as zero.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return (addr == ZERO_REG);
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port of the integer register file.
// The port selects a register, forces x0 to zero and, in builds with
// REGFILE_WRITE_BYPASS_EN defined, forwards same-cycle write data so that
// writeback-to-decode in one cycle sees the new value.
module reg_file_rdport
  import rv_pkg::*;
(
  input  xlen_t     regs [NREG],
  input  reg_addr_t raddr,
  input  logic      wen,
  input  logic      rst,
  input  reg_addr_t waddr,
  input  xlen_t     wdata,
  output xlen_t     rdata
);

`ifndef REGFILE_WRITE_BYPASS_EN
  // Write-side inputs only matter for forwarding; fold them into a sink.
  logic unused_bypass;
  assign unused_bypass = ^{wen, rst, waddr, wdata};
`endif

  // Select the addressed register; x0 masking takes priority over everything.
  always_comb begin
    rdata = regs[raddr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wen && !rst && (waddr == raddr) && !is_zero_reg(waddr)) begin
      rdata = wdata;
    end
`endif
    if (is_zero_reg(raddr)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit registers, x0 hardwired to zero.
// One synchronous write port and two independent combinational read ports.
// No handshake: every input is valid and every output is meaningful in
// every cycle; a write happens on the rising edge whenever i_wen is high.
// Optional build macro: REGFILE_WRITE_BYPASS_EN forwards write data to a
// read port that addresses the register being written in the same cycle.
module reg_file
  import rv_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  xlen_t     i_wdata,
  input  reg_addr_t i_waddr,
  input  logic      i_wen,
  output xlen_t     o_r1data,
  input  reg_addr_t i_r1addr,
  output xlen_t     o_r2data,
  input  reg_addr_t i_r2addr
);

  xlen_t regs [NREG];

  // Storage: asynchronous clear, single write per edge, writes to x0 dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (i_wen && !is_zero_reg(i_waddr)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  reg_file_rdport u_rdport1 (
    .regs  (regs),
    .raddr (i_r1addr),
    .wen   (i_wen),
    .rst   (i_rst),
    .waddr (i_waddr),
    .wdata (i_wdata),
    .rdata (o_r1data)
  );

  reg_file_rdport u_rdport2 (
    .regs  (regs),
    .raddr (i_r2addr),
    .wen   (i_wen),
    .rst   (i_rst),
    .waddr (i_waddr),
    .wdata (i_wdata),
    .rdata (o_r2data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. A plain array models the architectural
// registers; expected read values come from that array plus the x0 and
// (when REGFILE_WRITE_BYPASS_EN is defined) forwarding rules.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] r1data;
  logic [4:0]  r1addr;
  logic [31:0] r2data;
  logic [4:0]  r2addr;

  int n_vec;
  int n_err;

  logic [31:0] model [32];

  reg_file dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wdata  (wdata),
    .i_waddr  (waddr),
    .i_wen    (wen),
    .o_r1data (r1data),
    .i_r1addr (r1addr),
    .o_r2data (r2data),
    .i_r2addr (r2addr)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Reference: what a read of index a should show right now.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wen && !rst && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  function automatic logic bypass_on();
`ifdef REGFILE_WRITE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one rising edge, update the model, settle 1 time unit after.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wen && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    step();
    wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i += 7) begin
      r1addr = 5'(i); r2addr = 5'(31 - i);
      #1;
      n_vec++;
      if (r1data !== 32'h0 || r2data !== 32'h0) begin
        n_err++;
        $display("FAIL reset_read idx=%0d: got r1=%h r2=%h, want 0", i, r1data, r2data);
      end
    end
    step();
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_write_read();
    drive_write(5'h12, 32'hDEADBEEF);
    drive_write(5'h13, 32'hBABECAFE);
    r1addr = 5'h12; r2addr = 5'h13;
    step();
    n_vec++;
    if (r1data !== 32'hDEADBEEF || r2data !== 32'hBABECAFE) begin
      n_err++;
      $display("FAIL write_read: got r1=%h r2=%h, want DEADBEEF BABECAFE", r1data, r2data);
    end
  endtask

  task automatic test_x0();
    drive_write(5'h00, 32'hBBC0FFEE);
    drive_write(5'h01, 32'hEFBEADDE);
    r1addr = 5'h00; r2addr = 5'h01;
    #1;
    n_vec++;
    if (r1data !== 32'h0 || r2data !== 32'hEFBEADDE) begin
      n_err++;
      $display("FAIL x0_discard: got r1=%h r2=%h, want 00000000 EFBEADDE", r1data, r2data);
    end
  endtask

  task automatic test_async_reset();
    drive_write(5'd5, 32'h12345678);
    r1addr = 5'd5; r2addr = 5'd18;
    #1;
    n_vec++;
    if (r1data !== 32'h12345678) begin
      n_err++;
      $display("FAIL pre_reset_x5: got %h, want 12345678", r1data);
    end
    // Mid-cycle assertion: output must drop before the next edge.
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    n_vec++;
    if (r1data !== 32'h0 || r2data !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got r1=%h r2=%h, want 0 0", r1data, r2data);
    end
    // A write attempted while reset is held must be ignored.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hFFFF0000;
    step();
    wen = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r1addr = 5'(i); r2addr = 5'(31 - i);
      #1;
      n_vec++;
      if (r1data !== 32'h0 || r2data !== 32'h0) begin
        n_err++;
        $display("FAIL post_reset idx=%0d: got r1=%h r2=%h, want 0", i, r1data, r2data);
      end
    end
  endtask

  task automatic test_reset_release_write();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #3;
    rst = 1'b0;
    wen = 1'b1; waddr = 5'd3; wdata = 32'h0BADF00D;
    step();
    wen = 1'b0;
    r1addr = 5'd3;
    #1;
    n_vec++;
    if (r1data !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL first_edge_write: got %h, want 0BADF00D", r1data);
    end
  endtask

  task automatic test_wen_low();
    wen = 1'b0; waddr = 5'd7; wdata = 32'hFFFFFFFF;
    r1addr = 5'd7; r2addr = 5'd7;
    for (int k = 0; k < 4; k++) step();
    n_vec++;
    if (r1data !== 32'h0 || r2data !== 32'h0) begin
      n_err++;
      $display("FAIL wen_low_x7: got r1=%h r2=%h, want 0", r1data, r2data);
    end
  endtask

  task automatic test_rdw();
    logic [31:0] want;
    drive_write(5'd9, 32'h11112222);
    r1addr = 5'd9; r2addr = 5'd9;
    wen = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D;
    #1;
    want = bypass_on() ? 32'hCAFEF00D : 32'h11112222;
    n_vec++;
    if (r1data !== want || r2data !== want) begin
      n_err++;
      $display("FAIL rdw_before_edge: got r1=%h r2=%h, want %h", r1data, r2data, want);
    end
    step();
    wen = 1'b0;
    n_vec++;
    if (r1data !== 32'hCAFEF00D || r2data !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL rdw_after_edge: got r1=%h r2=%h, want CAFEF00D", r1data, r2data);
    end
    r1addr = 5'd0; r2addr = 5'd0;
    wen = 1'b1; waddr = 5'd0; wdata = 32'hCAFEF00D;
    #1;
    n_vec++;
    if (r1data !== 32'h0 || r2data !== 32'h0) begin
      n_err++;
      $display("FAIL rdw_x0_before: got r1=%h r2=%h, want 0", r1data, r2data);
    end
    step();
    wen = 1'b0;
    n_vec++;
    if (r1data !== 32'h0 || r2data !== 32'h0) begin
      n_err++;
      $display("FAIL rdw_x0_after: got r1=%h r2=%h, want 0", r1data, r2data);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] want1, want2;
    for (int i = 1; i < 32; i++) drive_write(5'(i), 32'hA5000000 | 32'(i));
    for (int i = 0; i < 32; i++) begin
      r1addr = 5'(i); r2addr = 5'(31 - i);
      #1;
      want1 = (i == 0) ? 32'h0 : (32'hA5000000 | 32'(i));
      want2 = (i == 31) ? 32'h0 : (32'hA5000000 | 32'(31 - i));
      n_vec++;
      if (r1data !== want1 || r2data !== want2) begin
        n_err++;
        $display("FAIL sweep idx=%0d: got r1=%h r2=%h, want %h %h",
                 i, r1data, r2data, want1, want2);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w1, w2;
    for (int n = 0; n < 400; n++) begin
      wen    = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      r1addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      r2addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      w1 = exp_rd(r1addr);
      w2 = exp_rd(r2addr);
      n_vec++;
      if (r1data !== w1 || r2data !== w2) begin
        n_err++;
        $display("FAIL random n=%0d a1=%0d a2=%0d: got r1=%h r2=%h, want %h %h",
                 n, r1addr, r2addr, r1data, r2data, w1, w2);
      end
      step();
    end
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r1addr = 5'(i); r2addr = 5'(i);
      #1;
      w1 = (i == 0) ? 32'h0 : model[i];
      n_vec++;
      if (r1data !== w1 || r2data !== w1) begin
        n_err++;
        $display("FAIL random_final idx=%0d: got r1=%h r2=%h, want %h", i, r1data, r2data, w1);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; r1addr = '0; r2addr = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    test_reset();
    test_write_read();
    test_x0();
    test_async_reset();
    test_reset_release_write();
    test_wen_low();
    test_rdw();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
